uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Purpose: locks the shared uart_tx stream to one of two requesters for a whole tlast-delimited message.
// Latency: data/valid/ready are combinational pass-through; each change of owner costs one idle arbitration cycle.
// Backpressure: m_tready reaches only the owner; the non-owner sees tready=0 and stays pending, untouched.
// Optional feature: define UART_ARB_TIMEOUT_EN to force-release a lock whose owner stalls for TIMEOUT_CYCLES.
module uart_tx_arbiter #(
    parameter int N_BITS         = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BITS-1:0] s0_tdata,
    input  logic              s0_tvalid,
    input  logic              s0_tlast,
    output logic              s0_tready,
    input  logic [N_BITS-1:0] s1_tdata,
    input  logic              s1_tvalid,
    input  logic              s1_tlast,
    output logic              s1_tready,
    output logic [N_BITS-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [1:0]        grant,
    output logic              timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_owner_q, last_owner_d;
    logic   own_tvalid;
    logic   own_tlast;
    logic   own_done;
    logic   stall_hit;

    // Both widths feed port/counter sizing and must be non-zero.
    if (N_BITS < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("uart_tx_arbiter: N_BITS and TIMEOUT_CYCLES must be at least 1");
    end

    // Select the current owner's valid/last so the rest of the logic is owner-agnostic.
    always_comb begin
        own_tvalid = 1'b0;
        own_tlast  = 1'b0;
        case (state_q)
            OWN0: begin
                own_tvalid = s0_tvalid;
                own_tlast  = s0_tlast;
            end
            OWN1: begin
                own_tvalid = s1_tvalid;
                own_tlast  = s1_tlast;
            end
            default: begin
                own_tvalid = 1'b0;
                own_tlast  = 1'b0;
            end
        endcase
    end

    // The message ends on the beat that actually transfers with tlast set.
    assign own_done = own_tvalid && m_tready && own_tlast;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] stall_inc;
    logic             timeout_q, timeout_d;
    logic             owning;

    // Count consecutive owner-idle cycles; any owner valid (even if backpressured) or leaving ownership clears it.
    always_comb begin
        owning      = (state_q != IDLE);
        stall_inc   = (stall_cnt_q == CNT_LIMIT) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
        stall_hit   = owning && !own_tvalid && (stall_inc == CNT_LIMIT);
        stall_cnt_d = (owning && !own_tvalid && !stall_hit) ? stall_inc : '0;
        timeout_d   = stall_hit;
    end

    // Stall counter and the one-cycle timeout pulse that accompanies the forced return to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign timeout = timeout_q && !rst;
`else
    assign stall_hit = 1'b0;
    assign timeout   = 1'b0;
`endif

    // Arbitrate from IDLE (round-robin on ties) and hold ownership until tlast or a stall release.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                if (s0_tvalid && (!s1_tvalid || last_owner_q)) begin
                    state_d      = OWN0;
                    last_owner_d = 1'b0;
                end else if (s1_tvalid) begin
                    state_d      = OWN1;
                    last_owner_d = 1'b1;
                end
            end
            OWN0, OWN1: begin
                if (own_done || stall_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and round-robin pointer; last_owner starts at 1 so s0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Pass the owner's stream straight through; everything is forced low while rst is high
    // so no beat can transfer in a reset cycle even though state updates on the next edge.
    always_comb begin
        m_tdata   = '0;
        m_tvalid  = 1'b0;
        s0_tready = 1'b0;
        s1_tready = 1'b0;
        grant     = 2'b00;
        if (!rst) begin
            case (state_q)
                OWN0: begin
                    m_tdata   = s0_tdata;
                    m_tvalid  = s0_tvalid;
                    s0_tready = m_tready;
                    grant     = 2'b01;
                end
                OWN1: begin
                    m_tdata   = s1_tdata;
                    m_tvalid  = s1_tvalid;
                    s1_tready = m_tready;
                    grant     = 2'b10;
                end
                default: begin
                    m_tdata   = '0;
                    m_tvalid  = 1'b0;
                    s0_tready = 1'b0;
                    s1_tready = 1'b0;
                    grant     = 2'b00;
                end
            endcase
        end
    end

endmodule
